// File: rtl/nes_controller_emulator_if.sv
// rtl/nes_controller_emulator_if.sv - NES pad serial link (latch, shift clock, data)
//
// Purpose: bundles the three wires between a NES console-side receiver and a
// pad so both ends can be connected with a single port.
// Signals:
//   nes_latch  receiver -> pad  active-high latch
//   nes_clk    receiver -> pad  shift clock, pad shifts on rising edge
//   nes_data   pad -> receiver  serial data, active-low (0 = pressed)
// Modports:
//   master  receiver side (drives latch/clk, reads data)
//   slave   pad side (reads latch/clk, drives data)

interface nes_controller_emulator_if;
  logic nes_latch;
  logic nes_clk;
  logic nes_data;

  modport master (
    output nes_latch,
    output nes_clk,
    input  nes_data
  );

  modport slave (
    input  nes_latch,
    input  nes_clk,
    output nes_data
  );
endinterface

// File: rtl/nes_controller_emulator.sv
// rtl/nes_controller_emulator.sv - 4021-style NES pad responder driven by latch/shift clock
//
// Purpose: samples eight active-high buttons while the latch is high and
// shifts them out MSB (A) first, active-low, one bit per shift-clock rise.
// Ports:
//   clk         system clock
//   reset       synchronous active-high reset
//   buttons     [7] A, [6] B, [5] Select, [4] Start, [3] Up, [2] Down, [1] Left, [0] Right
//   pad         slave side of the NES link (latch/clk in, data out)
//   bit_count   bits shifted since the last latch, 0..8 saturating
//   frame_done  one-cycle pulse on the 8th shift
//   link_idle   high once no latch rise has been seen for IDLE_TIMEOUT cycles

module nes_controller_emulator #(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 1048576
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 buttons,
  nes_controller_emulator_if.slave   pad,
  output logic [3:0]                 bit_count,
  output logic                       frame_done,
  output logic                       link_idle
);

  localparam int                IDLE_W   = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Input synchronisers, bit 0 is the first stage.
  logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
  logic [SYNC_STAGES-1:0] clk_sync_q,   clk_sync_d;
  logic                   latch_hist_q, latch_hist_d;
  logic                   clk_hist_q,   clk_hist_d;

  logic [7:0]        shreg_q,      shreg_d;
  logic [3:0]        cnt_q,        cnt_d;
  logic              nes_data_q,   nes_data_d;
  logic              frame_done_q, frame_done_d;
  logic [IDLE_W-1:0] idle_ctr_q,   idle_ctr_d;
  logic              framed_q,     framed_d;

  logic   latch_s;
  logic   nclk_s;
  logic   latch_rise;
  logic   nclk_rise;
  state_e state;

  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign nclk_s     = clk_sync_q[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_hist_q;
  assign nclk_rise  = nclk_s & ~clk_hist_q;

  // State is a pure decode of the synchronised latch and the shift count;
  // the latch level dominates everything else.
  always_comb begin
    state = ST_DONE;
    if (latch_s) begin
      state = ST_LOAD;
    end else if (cnt_q < 4'd8) begin
      state = ST_SHIFT;
    end
  end

  always_comb begin
    latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], pad.nes_latch};
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], pad.nes_clk};
    latch_hist_d = latch_s;
    clk_hist_d   = nclk_s;

    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    framed_d     = framed_q;

    unique case (state)
      ST_LOAD: begin
        shreg_d  = buttons;
        cnt_d    = 4'd0;
        framed_d = 1'b1;
      end
      ST_SHIFT: begin
        if (nclk_rise) begin
          shreg_d = {shreg_q[6:0], 1'b0};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            frame_done_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
      end
      default: begin
      end
    endcase

    // Registered output, computed from the current snapshot so it trails the
    // internal action by one cycle.
    nes_data_d = (state == ST_DONE) ? 1'b1 : ~shreg_q[7];

    if (latch_rise) begin
      idle_ctr_d = '0;
    end else if (idle_ctr_q == IDLE_MAX) begin
      idle_ctr_d = idle_ctr_q;
    end else begin
      idle_ctr_d = idle_ctr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      latch_sync_q <= '0;
      clk_sync_q   <= '0;
      latch_hist_q <= 1'b0;
      clk_hist_q   <= 1'b0;
      shreg_q      <= 8'h00;
      cnt_q        <= 4'd8;
      nes_data_q   <= 1'b1;
      frame_done_q <= 1'b0;
      idle_ctr_q   <= '0;
      framed_q     <= 1'b0;
    end else begin
      latch_sync_q <= latch_sync_d;
      clk_sync_q   <= clk_sync_d;
      latch_hist_q <= latch_hist_d;
      clk_hist_q   <= clk_hist_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      nes_data_q   <= nes_data_d;
      frame_done_q <= frame_done_d;
      idle_ctr_q   <= idle_ctr_d;
      framed_q     <= framed_d;
    end
  end

  // After reset the counter parks at 8 so stray shift clocks are ignored,
  // but no frame has been latched yet, so the visible count reads 0.
  assign bit_count    = framed_q ? cnt_q : 4'd0;
  assign frame_done   = frame_done_q;
  assign link_idle    = (idle_ctr_q == IDLE_MAX);
  assign pad.nes_data = nes_data_q;

endmodule

// File: tb/tb_nes_controller_emulator.sv
// tb/tb_nes_controller_emulator.sv - directed-vector bench for nes_controller_emulator

module tb_nes_controller_emulator;

  localparam int LATCH_CYC = 302;  // ~12 us at 25.175 MHz
  localparam int HALF_CYC  = 151;  // ~6 us

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] buttons = 8'h00;
  logic [3:0] bit_count;
  logic       frame_done;
  logic       link_idle;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  int fd_base;

  nes_controller_emulator_if pad_if ();

  nes_controller_emulator #(
    .SYNC_STAGES  (2),
    .IDLE_TIMEOUT (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .buttons    (buttons),
    .pad        (pad_if),
    .bit_count  (bit_count),
    .frame_done (frame_done),
    .link_idle  (link_idle)
  );

  always #20 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic latch_frame(input logic [7:0] b);
    buttons = b;
    pad_if.nes_latch = 1'b1;
    cyc(LATCH_CYC);
    pad_if.nes_latch = 1'b0;
    cyc(HALF_CYC);
  endtask

  // Check the bit presented before the next shift-clock rise, then pulse.
  task automatic shift_bit(input logic exp, input string tag);
    @(negedge clk);
    chk(tag, {7'd0, pad_if.nes_data}, {7'd0, exp});
    cyc(1);
    pad_if.nes_clk = 1'b1;
    cyc(HALF_CYC);
    pad_if.nes_clk = 1'b0;
    cyc(HALF_CYC);
  endtask

  task automatic shift_stream(input logic [7:0] exp_msb_first, input string tag);
    logic [7:0] e;
    e = exp_msb_first;
    for (int i = 0; i < 8; i++) begin
      shift_bit(e[7-i], $sformatf("%s_bit%0d", tag, i));
    end
  endtask

  initial begin
    pad_if.nes_latch = 1'b0;
    pad_if.nes_clk   = 1'b0;
    cyc(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_data", {7'd0, pad_if.nes_data}, 8'd1);
    chk("rst_count", {4'd0, bit_count}, 8'd0);
    chk("rst_fd", {7'd0, frame_done}, 8'd0);
    chk("rst_idle", {7'd0, link_idle}, 8'd0);
    cyc(70);
    @(negedge clk);
    chk("idle_set", {7'd0, link_idle}, 8'd1);

    // Frame 1: buttons 1010_0101 -> 0,1,0,1,1,0,1,0
    fd_base = fd_cnt;
    buttons = 8'hA5;
    pad_if.nes_latch = 1'b1;
    cyc(10);
    @(negedge clk);
    chk("idle_clr", {7'd0, link_idle}, 8'd0);
    chk("load_count", {4'd0, bit_count}, 8'd0);
    cyc(LATCH_CYC - 10);
    pad_if.nes_latch = 1'b0;
    cyc(HALF_CYC);
    shift_stream(8'b0101_1010, "f1");
    @(negedge clk);
    chk("f1_fd_once", 8'(fd_cnt - fd_base), 8'd1);
    chk("f1_count", {4'd0, bit_count}, 8'd8);
    chk("f1_done_data", {7'd0, pad_if.nes_data}, 8'd1);

    // Extra pulses after a complete frame are ignored.
    fd_base = fd_cnt;
    for (int i = 0; i < 4; i++) begin
      shift_bit(1'b1, $sformatf("extra_data%0d", i));
      @(negedge clk);
      chk($sformatf("extra_count%0d", i), {4'd0, bit_count}, 8'd8);
    end
    chk("extra_no_fd", 8'(fd_cnt - fd_base), 8'd0);

    // Buttons drop to 00 mid-shift; snapshot of FF still streams out.
    latch_frame(8'hFF);
    shift_bit(1'b0, "hold_bit0");
    shift_bit(1'b0, "hold_bit1");
    buttons = 8'h00;
    for (int i = 2; i < 8; i++) begin
      shift_bit(1'b0, $sformatf("hold_bit%0d", i));
    end

    // Abort after 3 shifts with a re-latch of 8'h80.
    latch_frame(8'h00);
    for (int i = 0; i < 3; i++) begin
      shift_bit(1'b1, $sformatf("pre_abort%0d", i));
    end
    fd_base = fd_cnt;
    buttons = 8'h80;
    pad_if.nes_latch = 1'b1;
    cyc(10);
    @(negedge clk);
    chk("abort_count", {4'd0, bit_count}, 8'd0);
    chk("abort_data", {7'd0, pad_if.nes_data}, 8'd0);
    chk("abort_no_fd", 8'(fd_cnt - fd_base), 8'd0);
    cyc(LATCH_CYC - 10);
    pad_if.nes_latch = 1'b0;
    cyc(HALF_CYC);
    shift_stream(8'b0111_1111, "ab");
    chk("ab_fd_once", 8'(fd_cnt - fd_base), 8'd1);

    // Reset after 5 shifts, then a clean frame with 8'h3C.
    latch_frame(8'hA5);
    shift_bit(1'b0, "pre_rst0");
    shift_bit(1'b1, "pre_rst1");
    shift_bit(1'b0, "pre_rst2");
    shift_bit(1'b1, "pre_rst3");
    shift_bit(1'b1, "pre_rst4");
    @(negedge clk);
    chk("pre_rst_count", {4'd0, bit_count}, 8'd5);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_data", {7'd0, pad_if.nes_data}, 8'd1);
    chk("mid_rst_count", {4'd0, bit_count}, 8'd0);
    fd_base = fd_cnt;
    latch_frame(8'h3C);
    shift_stream(8'b1100_0011, "pr");
    @(negedge clk);
    chk("pr_fd_once", 8'(fd_cnt - fd_base), 8'd1);
    chk("pr_count", {4'd0, bit_count}, 8'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
